uart_tx_buffered: RTL

Buffered UART transmitter: the transmit-side counterpart of the board's UART receive path. Accepts bytes through a valid/ready handshake into an internal FIFO and serialises them 8N1, LSB first, onto `uart_tx`. Sits between the capture/readout logic in `top` and the FPGA TX pin; bit timing uses the same clocks-per-bit parameter as the receiver.

---
 rtl/uart_tx_buffered_if.sv | 19 +
 rtl/uart_tx_buffered.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered_if.sv
// Byte write handshake into the buffered UART transmitter.
// The write happens on any cycle where data_valid and data_ready are both high.
interface uart_tx_buffered_if;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;

   modport master (
      output data_in,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_in,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a registered serialiser, LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit (11-bit frame).
module uart_tx_buffered #(
   parameter int unsigned DELAY_FRAMES = 8,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   uart_tx_buffered_if.slave             bus,
   output logic                          uart_tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [7:0] TimerMax = 8'(DELAY_FRAMES - 1);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StStart  = 3'd1;
   localparam logic [2:0] StData   = 3'd2;
   localparam logic [2:0] StStop   = 3'd3;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] StParity = 3'd4;
`endif

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [2:0]    state_q, state_d;
   logic [7:0]    timer_q, timer_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
   logic          par_q, par_d;
`endif

   logic       full;
   logic       push;
   logic       pop;
   logic       bit_done;
   logic [7:0] head;

   // Readiness depends on the count only, so a same-cycle pop never frees a slot.
   assign full           = (count_q == CW'(FIFO_DEPTH));
   assign bus.data_ready = ~full;
   assign push           = bus.data_valid & ~full;
   assign head           = mem_q[rptr_q];
   assign bit_done       = (timer_q == TimerMax);

   assign uart_tx    = tx_q;
   assign busy       = (state_q != StIdle) | (count_q != '0);
   assign fifo_count = count_q;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      // tx_d always reflects the level of the state being entered next cycle.
      case (state_q)
         StIdle: begin
            tx_d    = 1'b1;
            timer_d = '0;
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = StStart;
               tx_d    = 1'b0;
            end
         end
         StStart: begin
            if (bit_done) begin
               timer_d = '0;
               idx_d   = '0;
               state_d = StData;
               tx_d    = shift_q[0];
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         StData: begin
            if (bit_done) begin
               timer_d = '0;
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = StParity;
                  tx_d    = par_q;
`else
                  state_d = StStop;
                  tx_d    = 1'b1;
`endif
               end else begin
                  idx_d   = idx_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (bit_done) begin
               timer_d = '0;
               state_d = StStop;
               tx_d    = 1'b1;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
`endif
         StStop: begin
            if (bit_done) begin
               timer_d = '0;
               if (count_q != '0) begin
                  pop     = 1'b1;
                  state_d = StStart;
                  tx_d    = 1'b0;
               end else begin
                  state_d = StIdle;
                  tx_d    = 1'b1;
               end
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
            tx_d    = 1'b1;
         end
      endcase

      if (pop) begin
         shift_d = head;
`ifdef UART_TX_PARITY_EN
         par_d   = ^head;
`endif
      end
   end

   always_comb begin
      count_d = count_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= bus.data_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         state_q <= StIdle;
         timer_q <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule
